// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake and result bundle between the control unit and
// the bit-serial adder.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one shared 1-bit P/G full-adder cell,
// operands processed LSB first, one bit per clock.
module serial_add_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst,
  serial_add_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic             p;
  logic             g;
  logic             sum;
  logic             carry_next;
  logic [WIDTH-1:0] sr_next;

  always_comb begin
    p          = sa[0] ^ sb[0];
    g          = sa[0] & sb[0];
    sum        = p ^ carry;
    carry_next = g | (p & carry);
    sr_next    = {sum, sr[WIDTH-1:1]};
  end

  // The DONE cycle accepts a new start exactly like IDLE, giving
  // WIDTH+1 cycles per operation when start is held high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            sa    <= bus.a;
            sb    <= bus.op ? ~bus.b : bus.b;
            carry <= bus.op;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sr    <= sr_next;
          carry <= carry_next;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB at this step
            result_q <= sr_next;
            cout_q   <= carry_next;
            ovf_q    <= carry ^ carry_next;
            zero_q   <= (sr_next == '0);
            state    <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8: arithmetic vectors, flags,
// handshake timing, back-to-back issue and reset abandonment.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for done (max 20 edges); n = edges waited, -1 on timeout.
  task automatic wait_done(output int n, output bit busy_ok);
    n = -1;
    busy_ok = bus.busy;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (bus.busy) busy_ok = 1'b0;
        n = i;
        return;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int n, output bit busy_ok);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.op    = ~op;
    wait_done(n, busy_ok);
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 8'h3C;
    bus.b     = 8'h0F;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL reset_busy_done got=%b exp=00", {bus.busy, bus.done});
    else passes++;
    checks++;
    if (bus.result !== 8'h00)
      $display("FAIL reset_result got=%h exp=00", bus.result);
    else passes++;
    checks++;
    if ({bus.cout, bus.ovf, bus.zero} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {bus.cout, bus.ovf, bus.zero});
    else passes++;
    bus.start = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0)
      $display("FAIL reset_no_start got=%b exp=0", bus.busy);
    else passes++;
  endtask

  task automatic test_arith;
    logic [W-1:0] va [6] = '{8'h3C, 8'hFF, 8'h7F, 8'h80, 8'h05, 8'h03};
    logic [W-1:0] vb [6] = '{8'h0F, 8'h01, 8'h01, 8'h01, 8'h05, 8'h05};
    logic         vo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] vr [6] = '{8'h4B, 8'h00, 8'h80, 8'h7F, 8'h00, 8'hFE};
    logic [2:0]   vf [6] = '{3'b000, 3'b101, 3'b010, 3'b110, 3'b101, 3'b000};
    int n;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      do_op(vo[i], va[i], vb[i], n, ok);
      checks++;
      if (n !== W)
        $display("FAIL latency_%0d got=%0d exp=%0d", i, n, W);
      else passes++;
      checks++;
      if (!ok)
        $display("FAIL busy_window_%0d got=bad exp=busy_high_in_run_only", i);
      else passes++;
      checks++;
      if (bus.result !== vr[i])
        $display("FAIL result_%0d got=%h exp=%h", i, bus.result, vr[i]);
      else passes++;
      checks++;
      if ({bus.cout, bus.ovf, bus.zero} !== vf[i])
        $display("FAIL flags_%0d got=%b exp=%b", i, {bus.cout, bus.ovf, bus.zero}, vf[i]);
      else passes++;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.result} !== {2'b00, vr[i]})
        $display("FAIL idle_hold_%0d got=%b_%h exp=00_%h", i,
                 {bus.busy, bus.done}, bus.result, vr[i]);
      else passes++;
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit ok;
    bus.op    = 1'b0;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(n, ok);
    checks++;
    if (n !== W || bus.result !== 8'h03)
      $display("FAIL b2b_first got=%0d/%h exp=%0d/03", n, bus.result, W);
    else passes++;
    bus.a = 8'h10;
    bus.b = 8'h20;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b10)
      $display("FAIL b2b_accept got=%b exp=10", {bus.busy, bus.done});
    else passes++;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    wait_done(n, ok);
    checks++;
    if (n !== W || !ok)
      $display("FAIL b2b_period got=%0d exp=%0d", n + 1, W + 1);
    else passes++;
    checks++;
    if (bus.result !== 8'h30)
      $display("FAIL b2b_operand_change got=%h exp=30", bus.result);
    else passes++;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.result} !== {2'b00, 8'h30})
      $display("FAIL b2b_idle got=%b_%h exp=00_30", {bus.busy, bus.done}, bus.result);
    else passes++;
  endtask

  task automatic test_reset_mid_run;
    int  n;
    bit  ok;
    bit  saw_done;
    bus.op    = 1'b0;
    bus.a     = 8'h3C;
    bus.b     = 8'h0F;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.cout, bus.ovf, bus.zero} !== 13'd0)
      $display("FAIL midrun_reset got=%b%b_%h_%b exp=00_00_000",
               bus.busy, bus.done, bus.result, {bus.cout, bus.ovf, bus.zero});
    else passes++;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done)
      $display("FAIL midrun_no_done got=activity exp=quiet");
    else passes++;
    do_op(1'b0, 8'h3C, 8'h0F, n, ok);
    checks++;
    if (n !== W || bus.result !== 8'h4B)
      $display("FAIL midrun_restart got=%0d/%h exp=%0d/4b", n, bus.result, W);
    else passes++;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
